// File: rtl/alu_md_controller.sv
// Iterative RV32M-style multiply/divide unit with its own request FSM.
// Multiplies by shift-add and divides by restoring shift-subtract on operand
// magnitudes, one step per cycle, then applies the sign fix-up at the end.
module alu_md_controller #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             md_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [1:0]          f3_q, f3_d;       // only bits 1:0 matter after the MUL/DIV split
  logic                neg_q, neg_d;     // negate product / quotient
  logic                rem_neg_q, rem_neg_d;
  logic [2*WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [2*WIDTH-1:0]  prod_q, prod_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    quo_q, quo_d;
  logic [WIDTH-1:0]    dvsr_q, dvsr_d;
  logic [WIDTH-1:0]    result_q, result_d;

  logic                signed_a, signed_b, sign_a, sign_b;
  logic [WIDTH-1:0]    mag_a, mag_b;
  logic                div_zero, div_ovf;
  logic [WIDTH:0]      rem_sh, diff;
  logic [2*WIDTH-1:0]  prod_fin;
  logic [WIDTH-1:0]    quo_fin, rem_fin;

  assign md_op  = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;

  // Operand signedness, magnitudes and divide special cases for the incoming request.
  always_comb begin
    signed_a = (Funct3 == 3'b001) || (Funct3 == 3'b010) || (Funct3 == 3'b100) ||
               (Funct3 == 3'b110);
    signed_b = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    sign_a   = signed_a & op_a[WIDTH-1];
    sign_b   = signed_b & op_b[WIDTH-1];
    // Most negative value maps to itself, which is the correct unsigned magnitude.
    mag_a    = sign_a ? -op_a : op_a;
    mag_b    = sign_b ? -op_b : op_b;
    div_zero = Funct3[2] && (op_b == '0);
    div_ovf  = Funct3[2] && !Funct3[0] && (op_a == MostNeg) && (op_b == '1);
  end

  // Next-state, datapath step and result selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    result_d  = result_q;
    rem_sh    = '0;
    diff      = '0;
    prod_fin  = '0;
    quo_fin   = '0;
    rem_fin   = '0;

    unique case (state_q)
      StIdle: begin
        if (start && md_op) begin
          f3_d      = Funct3[1:0];
          neg_d     = sign_a ^ sign_b;
          rem_neg_d = sign_a;
          mcand_d   = {{WIDTH{1'b0}}, mag_a};
          mplier_d  = mag_b;
          prod_d    = '0;
          rem_d     = '0;
          quo_d     = mag_a;
          dvsr_d    = mag_b;
          cnt_d     = CntW'(WIDTH);
          if (div_zero) begin
            result_d = Funct3[1] ? op_a : '1;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = Funct3[1] ? '0 : MostNeg;
            state_d  = StDone;
          end else begin
            state_d = Funct3[2] ? StDiv : StMul;
          end
        end
      end

      StMul: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          prod_fin = neg_q ? -prod_d : prod_d;
          result_d = (f3_q == 2'b00) ? prod_fin[WIDTH-1:0] : prod_fin[2*WIDTH-1:WIDTH];
          state_d  = StDone;
        end
      end

      StDiv: begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvsr_q};
        // MSB of the trial difference is the borrow: clear means the divisor fits.
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          quo_fin  = neg_q ? -quo_d : quo_d;
          rem_fin  = rem_neg_q ? -rem_d : rem_d;
          result_d = f3_q[1] ? rem_fin : quo_fin;
          state_d  = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_md_controller.sv
// Bench for alu_md_controller at WIDTH=32: directed cases plus random ops
// checked against a 64-bit arithmetic reference model.
module tb_alu_md_controller;

  localparam int unsigned W = 32;
  localparam logic [31:0] Min32 = 32'h8000_0000;
  localparam logic [31:0] Ones32 = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    ALUOp;
  logic [6:0]    Funct7;
  logic [2:0]    Funct3;
  logic [W-1:0]  op_a, op_b;
  logic          md_op, busy, done;
  logic [W-1:0]  result;

  int total = 0;
  int bad = 0;

  alu_md_controller #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ALUOp  (ALUOp),
    .Funct7 (Funct7),
    .Funct3 (Funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .md_op  (md_op),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint     sa, sb, sp;
    logic [63:0] ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return Ones32;
        if (a == Min32 && b == Ones32) return Min32;
        sp = sa / sb; return sp[31:0];
      end
      3'd5: return (b == 0) ? Ones32 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == Min32 && b == Ones32) return 32'd0;
        sp = sa % sb; return sp[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3 >= 3'd4 && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == Min32 && b == Ones32) return 1;
    return W + 1;
  endfunction

  // Called at #1 after a rising edge with the DUT idle; returns likewise.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    logic [31:0] exp;
    int          lat, edges, busy_cnt;
    bit          got;
    exp = ref_model(f3, a, b);
    lat = ref_lat(f3, a, b);
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = f3; op_a = a; op_b = b; start = 1'b1;
    #1;
    chk({tag, "_mdop"}, {63'b0, md_op}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; Funct3 = 3'($urandom);
    edges = 1; busy_cnt = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy) busy_cnt++;
      if (done) begin got = 1'b1; break; end
      if (inject && edges == 5) begin
        start = 1'b1; Funct3 = 3'b101; op_a = $urandom; op_b = '0;
      end
      if (inject && edges == 8) start = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, "_done"}, {63'b0, got}, 64'd1);
    chk({tag, "_lat"}, 64'(edges), 64'(lat));
    chk({tag, "_busy"}, 64'(busy_cnt), 64'(lat));
    chk({tag, "_res"}, {32'b0, result}, {32'b0, exp});
    @(posedge clk); #1;
    chk({tag, "_idle"}, {62'b0, busy, done}, 64'd0);
    chk({tag, "_hold"}, {32'b0, result}, {32'b0, exp});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return Min32;
      2: return Ones32;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    bit          seen;

    rst_n = 1'b0; start = 1'b0; ALUOp = 2'b00; Funct7 = '0; Funct3 = '0;
    op_a = '0; op_b = '0;
    #1;
    chk("reset_state", {30'b0, busy, done, result}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First accept on the first edge after reset release; MUL latency/busy.
    run_op("mul_7", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op("mulhu", 3'd3, Ones32, Ones32, 1'b0);
    run_op("mulh", 3'd1, Ones32, Ones32, 1'b0);
    run_op("mulhsu", 3'd2, Ones32, 32'd2, 1'b0);
    run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu", 3'd5, 32'd100, 32'd7, 1'b0);
    run_op("remu", 3'd7, 32'd100, 32'd7, 1'b0);
    run_op("divu_z", 3'd5, 32'd5, 32'd0, 1'b0);
    run_op("rem_z", 3'd6, 32'd5, 32'd0, 1'b0);
    run_op("div_ovf", 3'd4, Min32, Ones32, 1'b0);
    run_op("rem_ovf", 3'd6, Min32, Ones32, 1'b0);

    // Non-M instruction: start ignored.
    ALUOp = 2'b10; Funct7 = 7'b0000000; Funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
    start = 1'b1;
    #1;
    chk("nonmd_mdop", {63'b0, md_op}, 64'd0);
    @(posedge clk); #1;
    chk("nonmd_busy", {62'b0, busy, done}, 64'd0);
    ALUOp = 2'b01; Funct7 = 7'b0000001;
    #1;
    chk("aluop_mdop", {63'b0, md_op}, 64'd0);
    @(posedge clk); #1;
    chk("aluop_busy", {62'b0, busy, done}, 64'd0);
    start = 1'b0;

    // Second start mid-MUL must not disturb the first operation.
    run_op("mul_inj", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);

    // Asynchronous reset at iteration 10 aborts with no done pulse.
    ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'd0; op_a = 32'd5; op_b = 32'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_state", {30'b0, busy, done, result}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("abort_nodone", {63'b0, seen}, 64'd0);

    // Random operations against the reference model, back to back.
    for (int n = 0; n < 48; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op($sformatf("rnd%0d_f%0d", n, rf3), rf3, ra, rb, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
